fp_mul_seq: RTL
===============

Name: fp_mul_seq

Overview:
Multicycle IEEE-754 single-precision multiply sequencer for the core's FP unit.
- Accepts two operands on a Start pulse and classifies special cases.
- Drives an iterative shift-add mantissa datapath, adds exponents, normalises, optionally rounds, and packs the result.
- Sits between the FP decode/issue logic and the writeback mux; one operation in flight at a time.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits consumed per MUL cycle. Legal values 1, 2, 4; MUL phase lasts 24/BITS_PER_CYCLE cycles.

Ports:
- CLK  input  1  clock, rising edge
- RESET_N  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only in IDLE
- FP_A  input  32  operand A, captured on the accepted Start
- FP_B  input  32  operand B, captured on the accepted Start
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle pulse; Result/Flags valid in that cycle
- Result  output  32  packed product; held until the next accepted Start
- Flags  output  3  {invalid, overflow, underflow}; held with Result

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; Busy=0, Done=0, Result=0, Flags=0; all internal registers cleared. Reset mid-operation aborts the operation with no Done.
- States and transitions:
  - IDLE -> UNPACK on Start=1.
  - UNPACK -> PACK if the operand pair is special, else -> MUL.
  - MUL -> NORM after 24/BITS_PER_CYCLE cycles.
  - NORM -> PACK.
  - PACK -> DONE.
  - DONE -> IDLE.
- Start outside IDLE is ignored, including in DONE; it is not queued.
- Latency, from the Start-sampling edge to Done high: normal operands 3+24/BITS_PER_CYCLE cycles (27 at default); special operands 2 cycles.
- Result and Flags update on the PACK->DONE edge. Done = (state==DONE).
- UNPACK: denormals are flushed to signed zero. Sign = sA^sB.
- Exponent sum is held in 10-bit signed: Ea+Eb-127.
- MUL: 48-bit product accumulator. Each cycle adds mantA shifted by the current multiplier bit position when the corresponding bit of mantB is set; BITS_PER_CYCLE bits per cycle, LSB first.
- NORM: if product[47]=1, take fraction = product[46:24], exponent+1. Otherwise fraction = product[45:23]. Guard and sticky bits are derived from the remaining low bits.
- PACK (normal path):
  - Exponent >= 255 -> signed infinity, overflow=1.
  - Exponent <= 0 -> signed zero, underflow=1.
- Special operand cases:
  - Any NaN, or 0 x inf -> 0x7FC00000, invalid=1.
  - inf x nonzero -> signed infinity.
  - zero x finite -> signed zero, Flags=0.

Optional Feature:
- Macro FP_MUL_RNE_EN.
- Defined: round-to-nearest-even in PACK using lsb, guard and sticky. A rounding carry-out renormalises (fraction=0, exponent+1) and is rechecked for overflow. Latency is unchanged.
- Undefined: truncation; guard and sticky are ignored and their logic is not synthesised.

Decomposition:
- Shared package fp_pkg:
  - EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000.
  - Flag bit indices.
  - State enum: IDLE, UNPACK, MUL, NORM, PACK, DONE.
- Sub-module fp_mul_mant_iter: the 48-bit accumulator plus one BITS_PER_CYCLE shift-add step, with load/step controls driven by the FSM. The FSM and the pack logic stay in fp_mul_seq.

Test Plan:
- A=0x3FC00000 (1.5), B=0x40000000 (2.0), Start one cycle -> Busy high next cycle; Done pulses exactly 27 cycles later; Result=0x40400000, Flags=0; Result still held 5 cycles after Done.
- A=0x00000000, B=0x7F800000 -> Done after 2 cycles; Result=0x7FC00000, Flags=3'b100. A=0x80000000, B=0x3F800000 -> Result=0x80000000, Flags=0.
- A=B=0x7F000000 -> Result=0x7F800000, Flags=3'b010. A=B=0x00800000 -> Result=0x00000000, Flags=3'b001.
- A=0x3F800001, B=0x3FC00000 (tie case) -> Result=0x3FC00001 without FP_MUL_RNE_EN; Result=0x3FC00002 with it.
- Start held high for 40 cycles with changing operands -> exactly one Done, computed from the operands captured on the first edge; the next operation is accepted only after DONE->IDLE.
- RESET_N driven low at MUL cycle 10 for 1 cycle -> all outputs 0 asynchronously; no Done. A fresh Start afterwards completes normally with latency 27.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, flag indices and FSM state encoding for the FP multiply sequencer.
// Optional build macro used by the sequencer: FP_MUL_RNE_EN (round-to-nearest-even).
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 24;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Flags vector is {invalid, overflow, underflow}
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MUL    = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/fp_mul_mant_iter.sv
// Iterative shift-add mantissa multiplier: 48-bit accumulator consuming
// BITS_PER_CYCLE multiplier bits (LSB first) per step.
module fp_mul_mant_iter
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] mant_a,
  input  logic [23:0] mant_b,
  output logic [47:0] product
);

  logic [47:0] acc;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] acc_next;

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {24'b0, mant_a};
      mplier <= mant_b;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
    end
  end

  assign product = acc;

endmodule

// File: rtl/fp_mul_seq.sv
// Multicycle IEEE-754 single-precision multiply sequencer (one operation in flight).
// Build macro FP_MUL_RNE_EN: round-to-nearest-even in PACK; undefined = truncation.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        Start,
  input  logic [31:0] FP_A,
  input  logic [31:0] FP_B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [2:0]  Flags,
  output state_t      dbg_state
);

  // Handshake: Start is a request taken only while Busy=0 (IDLE); while Busy=1
  // Start is ignored and not queued. Done pulses once with Result/Flags valid.

  localparam int MUL_CYCLES = MANT_W / BITS_PER_CYCLE;
  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic signed [9:0] EXP_OVF  = 10'(EXP_MAX);
  localparam logic signed [9:0] EXP_BIAS_S = 10'(EXP_BIAS);

  state_t             state;
  logic [31:0]        a_q, b_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic               special_q;
  logic [31:0]        spec_result_q;
  logic [2:0]         spec_flags_q;
  logic [22:0]        frac_q;
  logic [4:0]         cnt;
  logic [47:0]        product;

  // Operand classification; exponent 0 covers zeros and flushed denormals
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab, is_special;
  logic [31:0] spec_result;
  logic [2:0]  spec_flags;

  assign a_zero  = (a_q[30:23] == 8'h00);
  assign b_zero  = (b_q[30:23] == 8'h00);
  assign a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'b0);
  assign b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'b0);
  assign a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'b0);
  assign b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'b0);
  assign sign_ab = a_q[31] ^ b_q[31];
  assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  always_comb begin
    spec_result = '0;
    spec_flags  = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_result = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_result = {sign_ab, 8'hFF, 23'b0};
    end else begin
      spec_result = {sign_ab, 31'b0};
    end
  end

  fp_mul_mant_iter #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_mant (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .load    (state == UNPACK),
    .step    (state == MUL),
    .mant_a  ({1'b1, a_q[22:0]}),
    .mant_b  ({1'b1, b_q[22:0]}),
    .product (product)
  );

  // Normalisation select: product is in [1,4), so at most one bit of shift
  logic [22:0] norm_frac;
  assign norm_frac = product[47] ? product[46:24] : product[45:23];

`ifdef FP_MUL_RNE_EN
  logic guard_q, sticky_q, norm_guard, norm_sticky;
  assign norm_guard  = product[47] ? product[23] : product[22];
  assign norm_sticky = product[47] ? (|product[22:0]) : (|product[21:0]);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^product[22:0];
`endif

  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;
  logic [31:0]       pack_result;
  logic [2:0]        pack_flags;

  always_comb begin
    frac_r = frac_q;
    exp_r  = exp_q;
`ifdef FP_MUL_RNE_EN
    begin
      logic [23:0] frac_sum;
      frac_sum = {1'b0, frac_q} + {23'b0, guard_q & (sticky_q | frac_q[0])};
      frac_r   = frac_sum[22:0];
      if (frac_sum[23]) exp_r = exp_q + 10'sd1;
    end
`endif
    pack_result = '0;
    pack_flags  = '0;
    if (special_q) begin
      pack_result = spec_result_q;
      pack_flags  = spec_flags_q;
    end else if (exp_r >= EXP_OVF) begin
      pack_result = {sign_q, 8'hFF, 23'b0};
      pack_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      pack_result = {sign_q, 31'b0};
      pack_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      pack_result = {sign_q, exp_r[7:0], frac_r};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Result        <= '0;
      Flags         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      spec_result_q <= '0;
      spec_flags_q  <= '0;
      frac_q        <= '0;
      cnt           <= '0;
`ifdef FP_MUL_RNE_EN
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_q   <= FP_A;
            b_q   <= FP_B;
            Busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q        <= sign_ab;
          exp_q         <= $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - EXP_BIAS_S;
          special_q     <= is_special;
          spec_result_q <= spec_result;
          spec_flags_q  <= spec_flags;
          cnt           <= '0;
          state         <= is_special ? PACK : MUL;
        end
        MUL: begin
          cnt <= cnt + 5'd1;
          if (cnt == MUL_LAST) state <= NORM;
        end
        NORM: begin
          frac_q <= norm_frac;
          if (product[47]) exp_q <= exp_q + 10'sd1;
`ifdef FP_MUL_RNE_EN
          guard_q  <= norm_guard;
          sticky_q <= norm_sticky;
`endif
          state <= PACK;
        end
        PACK: begin
          Result <= pack_result;
          Flags  <= pack_flags;
          Done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
